debug_controller: RTL and testbench

//  Command sequencer between the UART (RX/TX) and the MIPS core under debug.

---
 rtl/debug_controller.sv | 159 +++++++++++++++
 tb/tb_debug_controller.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_controller.sv
// Debug command sequencer between the UART and the MIPS core under debug.
// Gates the core clock enable and streams a frozen debug-bus snapshot to TX, LSB byte first.
module debug_controller #(
  parameter int unsigned D_BIT   = 7,
  parameter int unsigned DBG_W   = 322,
  parameter int unsigned N_BYTES = 41
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [D_BIT:0]   rx_dato_out,
  input  logic             rx_done,
  input  logic             tx_done,
  input  logic [DBG_W-1:0] debug_signal,
  input  logic             cpu_halt,
  output logic [D_BIT:0]   tx_dato_in,
  output logic             tx_start,
  output logic             cpu_en,
  output logic             busy
);

  localparam int unsigned BYTE_W = D_BIT + 1;
  localparam int unsigned SNAP_W = N_BYTES * BYTE_W;
  localparam int unsigned CNT_W  = 6;

  localparam logic [D_BIT:0] CMD_PING = BYTE_W'(8'h61);  // "a"
  localparam logic [D_BIT:0] CMD_DUMP = BYTE_W'(8'h64);  // "d"
  localparam logic [D_BIT:0] CMD_STEP = BYTE_W'(8'h73);  // "s"
  localparam logic [D_BIT:0] CMD_RUN  = BYTE_W'(8'h63);  // "c"
  localparam logic [D_BIT:0] CMD_HALT = BYTE_W'(8'h68);  // "h"
  localparam logic [D_BIT:0] RSP_PING = BYTE_W'(8'h70);  // "p"

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    SNAP,
    SEND,
    WAIT_TX
  } state_t;

  state_t             state, state_nxt;
  logic               ping, ping_nxt;
  logic [CNT_W-1:0]   byte_cnt, byte_cnt_nxt;
  logic [SNAP_W-1:0]  snapshot, snapshot_nxt;
  logic               cpu_en_nxt;
  logic               tx_start_nxt;
  logic [D_BIT:0]     tx_dato_nxt;
  logic               busy_nxt;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ping       <= 1'b0;
      byte_cnt   <= '0;
      snapshot   <= '0;
      cpu_en     <= 1'b0;
      tx_start   <= 1'b0;
      tx_dato_in <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      ping       <= ping_nxt;
      byte_cnt   <= byte_cnt_nxt;
      snapshot   <= snapshot_nxt;
      cpu_en     <= cpu_en_nxt;
      tx_start   <= tx_start_nxt;
      tx_dato_in <= tx_dato_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt    = state;
    ping_nxt     = ping;
    byte_cnt_nxt = byte_cnt;
    snapshot_nxt = snapshot;
    cpu_en_nxt   = 1'b0;
    tx_start_nxt = 1'b0;
    tx_dato_nxt  = tx_dato_in;

    unique case (state)
      IDLE: begin
        if (rx_done) begin
          if (rx_dato_out == CMD_PING) begin
            tx_dato_nxt  = RSP_PING;
            tx_start_nxt = 1'b1;
            ping_nxt     = 1'b1;
            state_nxt    = WAIT_TX;
          end else if (rx_dato_out == CMD_DUMP) begin
            state_nxt = SNAP;
          end else if (rx_dato_out == CMD_STEP) begin
            // a halted core still gets the dump, just no enable pulse
            cpu_en_nxt = !cpu_halt;
            state_nxt  = STEP;
          end else if (rx_dato_out == CMD_RUN) begin
            if (cpu_halt) begin
              state_nxt = SNAP;
            end else begin
              cpu_en_nxt = 1'b1;
              state_nxt  = RUN;
            end
          end
        end
      end

      RUN: begin
        if (cpu_halt || (rx_done && (rx_dato_out == CMD_HALT))) begin
          state_nxt = SNAP;
        end else begin
          cpu_en_nxt = 1'b1;
        end
      end

      STEP: begin
        state_nxt = SNAP;
      end

      // Byte 0 launches on the capture edge itself so the first tx_start
      // follows SNAP directly; SEND handles every later byte.
      SNAP: begin
        snapshot_nxt = SNAP_W'(debug_signal);
        byte_cnt_nxt = '0;
        tx_dato_nxt  = snapshot_nxt[BYTE_W-1:0];
        tx_start_nxt = 1'b1;
        state_nxt    = WAIT_TX;
      end

      SEND: begin
        tx_dato_nxt  = snapshot[byte_cnt * BYTE_W +: BYTE_W];
        tx_start_nxt = 1'b1;
        state_nxt    = WAIT_TX;
      end

      WAIT_TX: begin
        if (tx_done) begin
          if (ping) begin
            ping_nxt  = 1'b0;
            state_nxt = IDLE;
          end else if (byte_cnt == CNT_W'(N_BYTES - 1)) begin
            byte_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            byte_cnt_nxt = byte_cnt + CNT_W'(1);
            state_nxt    = SEND;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE) && (state_nxt != RUN);
  end

endmodule

// File: tb/tb_debug_controller.sv
// Self-checking bench for debug_controller: directed command sequence with random
// debug patterns and TX handshake delays, checked against a byte-stream reference.
module tb_debug_controller;

  localparam int unsigned DBG_W   = 322;
  localparam int unsigned N_BYTES = 41;
  localparam int unsigned SNAP_W  = N_BYTES * 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_dato_out = 8'h00;
  logic             rx_done = 1'b0;
  logic             tx_done;
  logic [DBG_W-1:0] debug_signal;
  logic             cpu_halt = 1'b0;
  logic [7:0]       tx_dato_in;
  logic             tx_start;
  logic             cpu_en;
  logic             busy;

  logic [DBG_W-1:0] dbg_base = '0;
  logic [31:0]      core_cnt = 32'd0;
  int               cyc = 0;

  int               n_assert = 0;
  int               n_fail = 0;

  logic [7:0]       tx_q[$];
  int               start_q[$];
  int               done_q[$];
  int               hold_bad = 0;
  int               last_rx_cyc = 0;
  int unsigned      ref_cnt = 0;

  debug_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_dato_out  (rx_dato_out),
    .rx_done      (rx_done),
    .tx_done      (tx_done),
    .debug_signal (debug_signal),
    .cpu_halt     (cpu_halt),
    .tx_dato_in   (tx_dato_in),
    .tx_start     (tx_start),
    .cpu_en       (cpu_en),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in core: a free counter advanced only while enabled, visible on the debug bus
  always @(posedge clk) if (cpu_en === 1'b1) core_cnt <= core_cnt + 32'd1;
  assign debug_signal = dbg_base ^ DBG_W'(core_cnt);

  // Capture every launched byte
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        tx_q.push_back(tx_dato_in);
        start_q.push_back(cyc);
      end
    end
  end

  // TX model: finish each byte 1..3 cycles after launch, checking the byte is held
  initial begin
    logic [7:0] b;
    int d;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        b = tx_dato_in;
        d = int'($urandom_range(3, 1));
        repeat (d) begin
          @(negedge clk);
          if (rst_n && tx_dato_in !== b) hold_bad++;
        end
        tx_done = 1'b1;
        done_q.push_back(cyc);
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Assumes the caller is at a negedge; returns at the negedge of the following cycle
  task automatic send_rx(input logic [7:0] b);
    rx_dato_out = b;
    rx_done     = 1'b1;
    last_rx_cyc = cyc;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic clear_logs();
    tx_q.delete();
    start_q.delete();
    done_q.delete();
    hold_bad = 0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 64'(busy), 64'(0));
    wait_cycles(6);
  endtask

  task automatic randomize_base();
    for (int i = 0; i < int'(DBG_W); i++) dbg_base[i] = 1'($urandom_range(1, 0));
  endtask

  // Reference: byte k of a dump is the zero-extended bus value shifted down by 8*k
  function automatic logic [7:0] exp_byte(input logic [SNAP_W-1:0] v, input int k);
    logic [SNAP_W-1:0] s;
    s = v >> (8 * k);
    return s[7:0];
  endfunction

  function automatic logic [SNAP_W-1:0] ref_value(input logic [DBG_W-1:0] base,
                                                  input int unsigned cnt);
    logic [DBG_W-1:0] v;
    v = base ^ DBG_W'(cnt);
    return SNAP_W'(v);
  endfunction

  task automatic compare_dump(input string tag, input logic [SNAP_W-1:0] v, input int lat0);
    logic [7:0] got;
    int gap_bad = 0;
    check({tag, "_len"}, 64'(tx_q.size()), 64'(N_BYTES));
    for (int k = 0; k < int'(N_BYTES); k++) begin
      got = (k < tx_q.size()) ? tx_q[k] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, k), 64'(got), 64'(exp_byte(v, k)));
    end
    for (int i = 0; i + 1 < start_q.size(); i++) begin
      if (i >= done_q.size() || start_q[i+1] - done_q[i] != 2) gap_bad++;
    end
    check({tag, "_gap"}, 64'(gap_bad), 64'(0));
    check({tag, "_hold"}, 64'(hold_bad), 64'(0));
    if (lat0 >= 0)
      check({tag, "_latency"}, 64'((start_q.size() > 0) ? start_q[0] - last_rx_cyc : -1),
            64'(lat0));
  endtask

  initial begin
    int tc;
    int th;
    int n;
    logic [SNAP_W-1:0] v;

    // Reset state
    wait_cycles(3);
    check("rst_cpu_en", 64'(cpu_en), 64'(0));
    check("rst_tx_start", 64'(tx_start), 64'(0));
    check("rst_tx_dato", 64'(tx_dato_in), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    wait_cycles(2);

    // Unknown byte in IDLE is ignored
    send_rx(8'h78);
    check("unk_busy", 64'(busy), 64'(0));
    check("unk_tx_start", 64'(tx_start), 64'(0));
    check("unk_cpu_en", 64'(cpu_en), 64'(0));

    // Ping
    clear_logs();
    send_rx(8'h61);
    check("ping_start", 64'(tx_start), 64'(1));
    check("ping_byte", 64'(tx_dato_in), 64'(8'h70));
    wait_idle("ping", 50);
    check("ping_len", 64'(tx_q.size()), 64'(1));
    check("ping_cpu_en", 64'(cpu_en), 64'(0));
    check("ping_core", 64'(core_cnt), 64'(ref_cnt));

    // Dump of byte-index pattern; bus scrambled right after capture
    for (int k = 0; k < int'(DBG_W); k++) dbg_base[k] = 1'(((k / 8) >> (k % 8)) & 1);
    v = ref_value(dbg_base, ref_cnt);
    clear_logs();
    send_rx(8'h64);
    check("dump_snap_busy", 64'(busy), 64'(1));
    check("dump_snap_start", 64'(tx_start), 64'(0));
    @(negedge clk);
    check("dump_first_start", 64'(tx_start), 64'(1));
    check("dump_first_byte", 64'(tx_dato_in), 64'(8'h00));
    randomize_base();
    wait_idle("dump", 1000);
    compare_dump("dump", v, 2);
    check("dump_last_pad", 64'(exp_byte(v, 40)), 64'(8'h00));

    // Random-pattern dumps
    for (int r = 0; r < 2; r++) begin
      randomize_base();
      v = ref_value(dbg_base, ref_cnt);
      clear_logs();
      send_rx(8'h64);
      wait_idle("rdump", 1000);
      compare_dump($sformatf("rdump%0d", r), v, 2);
    end

    // Single step
    randomize_base();
    clear_logs();
    send_rx(8'h73);
    check("step_en_hi", 64'(cpu_en), 64'(1));
    @(negedge clk);
    check("step_en_lo", 64'(cpu_en), 64'(0));
    wait_idle("step", 1000);
    ref_cnt = ref_cnt + 1;
    check("step_core", 64'(core_cnt), 64'(ref_cnt));
    compare_dump("step", ref_value(dbg_base, ref_cnt), 3);

    // Run, ignored byte, then host halt
    clear_logs();
    send_rx(8'h63);
    tc = last_rx_cyc;
    check("run_en", 64'(cpu_en), 64'(1));
    wait_cycles(int'($urandom_range(8, 3)));
    send_rx(8'h78);
    check("run_x_en", 64'(cpu_en), 64'(1));
    check("run_x_busy", 64'(busy), 64'(0));
    wait_cycles(int'($urandom_range(8, 2)));
    send_rx(8'h68);
    th = last_rx_cyc;
    check("runh_en_off", 64'(cpu_en), 64'(0));
    check("runh_busy", 64'(busy), 64'(1));
    wait_idle("runh", 1000);
    ref_cnt = ref_cnt + unsigned'(th - tc);
    check("runh_core", 64'(core_cnt), 64'(ref_cnt));
    compare_dump("runh", ref_value(dbg_base, ref_cnt), -1);

    // Run ended by the core halting
    clear_logs();
    send_rx(8'h63);
    tc = last_rx_cyc;
    wait_cycles(int'($urandom_range(9, 2)));
    cpu_halt = 1'b1;
    th = cyc;
    @(negedge clk);
    check("runc_en_off", 64'(cpu_en), 64'(0));
    wait_idle("runc", 1000);
    ref_cnt = ref_cnt + unsigned'(th - tc);
    check("runc_core", 64'(core_cnt), 64'(ref_cnt));
    compare_dump("runc", ref_value(dbg_base, ref_cnt), -1);

    // Already halted: "c" dumps without enabling, "s" dumps without stepping
    clear_logs();
    send_rx(8'h63);
    check("halted_c_en", 64'(cpu_en), 64'(0));
    check("halted_c_busy", 64'(busy), 64'(1));
    wait_idle("halted_c", 1000);
    compare_dump("halted_c", ref_value(dbg_base, ref_cnt), 2);
    clear_logs();
    send_rx(8'h73);
    check("halted_s_en", 64'(cpu_en), 64'(0));
    wait_idle("halted_s", 1000);
    check("halted_s_core", 64'(core_cnt), 64'(ref_cnt));
    compare_dump("halted_s", ref_value(dbg_base, ref_cnt), 3);
    cpu_halt = 1'b0;
    wait_cycles(2);

    // Halt byte and core halt in the same cycle give a single dump
    clear_logs();
    send_rx(8'h63);
    tc = last_rx_cyc;
    wait_cycles(int'($urandom_range(6, 2)));
    cpu_halt = 1'b1;
    send_rx(8'h68);
    th = last_rx_cyc;
    check("both_en_off", 64'(cpu_en), 64'(0));
    wait_idle("both", 1000);
    wait_cycles(10);
    ref_cnt = ref_cnt + unsigned'(th - tc);
    check("both_core", 64'(core_cnt), 64'(ref_cnt));
    compare_dump("both", ref_value(dbg_base, ref_cnt), -1);
    cpu_halt = 1'b0;
    wait_cycles(2);

    // Commands arriving mid-dump are dropped
    randomize_base();
    v = ref_value(dbg_base, ref_cnt);
    clear_logs();
    send_rx(8'h64);
    wait_cycles(5);
    send_rx(8'h61);
    wait_cycles(7);
    send_rx(8'h73);
    wait_cycles(3);
    send_rx(8'h64);
    wait_idle("drop", 1000);
    check("drop_core", 64'(core_cnt), 64'(ref_cnt));
    compare_dump("drop", v, -1);

    // Reset in the middle of a dump
    randomize_base();
    v = ref_value(dbg_base, ref_cnt);
    clear_logs();
    send_rx(8'h64);
    n = 0;
    while (tx_q.size() < 11 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached", 64'(tx_q.size()), 64'(11));
    rst_n = 1'b0;
    #1;
    check("mid_rst_start", 64'(tx_start), 64'(0));
    check("mid_rst_dato", 64'(tx_dato_in), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_en", 64'(cpu_en), 64'(0));
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(20);
    check("mid_no_restart", 64'(tx_q.size()), 64'(11));
    check("mid_busy_after", 64'(busy), 64'(0));
    clear_logs();
    send_rx(8'h64);
    @(negedge clk);
    check("mid_new_first", 64'(tx_dato_in), 64'(exp_byte(v, 0)));
    wait_idle("mid_new", 1000);
    compare_dump("mid_new", v, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
